mem_port_sequencer: RTL and testbench

- Shares the processor's single-port 1024x16 block RAM between two requesters.
- Fetch requester: instruction fetch, read-only, feeds IR. Data requester: stack/data load-store.
- Grants one access per cycle, returns read data a fixed number of cycles later, and pulses the IR load strobe for returned fetches.
- Sits between the control unit/PC logic and the memory + IR + extend/shift datapath.

---
 rtl/mem_port_sequencer_pkg.sv | 21 ++
 rtl/mem_port_sequencer_if.sv | 41 ++++
 rtl/mem_port_sequencer_rd_tag_pipe.sv | 48 ++++
 rtl/mem_port_sequencer.sv | 96 +++++++++
 tb/tb_mem_port_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer_pkg
// Brief    : Shared constants and read-source tag encoding for the memory port.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_sequencer_pkg;

    localparam int ADDR_W             = 10;
    localparam int DATA_W             = 16;
    localparam int STARVE_MAX_DEFAULT = 2;
    localparam int STARVE_W           = 3;

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } rd_tag_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer_if
// Brief    : Requester, read-return and block-RAM signals of the memory port.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_sequencer_if;
    import mem_port_sequencer_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              rvalid_f;
    logic              rvalid_d;
    logic [DATA_W-1:0] rdata;
    logic              ir_load;
    logic [ADDR_W-1:0] mem_addra;
    logic              mem_wea;
    logic [DATA_W-1:0] mem_dina;
    logic [DATA_W-1:0] mem_douta;
    logic              busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_douta,
        output f_gnt, d_gnt, rvalid_f, rvalid_d, rdata, ir_load,
               mem_addra, mem_wea, mem_dina, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_douta,
        input  f_gnt, d_gnt, rvalid_f, rvalid_d, rdata, ir_load,
               mem_addra, mem_wea, mem_dina, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_sequencer_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_rd_tag_pipe
// Brief    : Two-stage read source tag pipeline with read data capture.
// Revision : 1.0 - initial release
// ============================================================================
module mem_rd_tag_pipe
    import mem_port_sequencer_pkg::*;
(
    input  wire logic              CLK,
    input  wire logic              reset,
    input  wire rd_tag_e           tag_in,
    input  wire logic [DATA_W-1:0] mem_douta,
    output logic                   rvalid_f,
    output logic                   rvalid_d,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy
);

    rd_tag_e           r_tag_s1;
    rd_tag_e           r_tag_s2;
    logic [DATA_W-1:0] r_rdata;
    logic              r_busy;

    // Stage 1 lines up with the cycle the RAM output is valid; capture there.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tag_s1 <= TAG_NONE;
            r_tag_s2 <= TAG_NONE;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_tag_s1 <= tag_in;
            r_tag_s2 <= r_tag_s1;
            if (r_tag_s1 != TAG_NONE) begin
                r_rdata <= mem_douta;
            end
            r_busy <= (tag_in != TAG_NONE) || (r_tag_s1 != TAG_NONE);
        end
    end

    assign rvalid_f = (r_tag_s2 == TAG_FETCH);
    assign rvalid_d = (r_tag_s2 == TAG_DATA);
    assign rdata    = r_rdata;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_sequencer
// Brief    : Arbitrates fetch and data requesters onto one single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_sequencer
    import mem_port_sequencer_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  wire logic           CLK,
    input  wire logic           reset,
    mem_port_sequencer_if.slave bus
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic [ADDR_W-1:0]   r_last_addr;
    logic                w_f_gnt;
    logic                w_d_gnt;
    rd_tag_e             w_tag_in;
    logic                w_rvalid_f;
    logic                w_rvalid_d;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_busy;

    // Data has priority unless fetch has been starved long enough.
    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!reset) begin
            if (bus.f_req && (!bus.d_req || (r_starve_cnt == C_STARVE_MAX))) begin
                w_f_gnt = 1'b1;
            end else if (bus.d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_tag_in = TAG_NONE;
        if (w_f_gnt) begin
            w_tag_in = TAG_FETCH;
        end else if (w_d_gnt && !bus.d_we) begin
            w_tag_in = TAG_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.f_req || w_f_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt < C_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Idle cycles keep the last address on the RAM pins to avoid toggling.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_last_addr <= '0;
        end else if (w_f_gnt) begin
            r_last_addr <= bus.f_addr;
        end else if (w_d_gnt) begin
            r_last_addr <= bus.d_addr;
        end
    end

    assign bus.mem_addra = w_f_gnt ? bus.f_addr : (w_d_gnt ? bus.d_addr : r_last_addr);
    assign bus.mem_wea   = w_d_gnt & bus.d_we;
    assign bus.mem_dina  = w_d_gnt ? bus.d_wdata : '0;
    assign bus.f_gnt     = w_f_gnt;
    assign bus.d_gnt     = w_d_gnt;

    mem_rd_tag_pipe u_rd_tag_pipe (
        .CLK       (CLK),
        .reset     (reset),
        .tag_in    (w_tag_in),
        .mem_douta (bus.mem_douta),
        .rvalid_f  (w_rvalid_f),
        .rvalid_d  (w_rvalid_d),
        .rdata     (w_rdata),
        .busy      (w_busy)
    );

    assign bus.rvalid_f = w_rvalid_f;
    assign bus.rvalid_d = w_rvalid_d;
    assign bus.ir_load  = w_rvalid_f;
    assign bus.rdata    = w_rdata;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_sequencer
// Brief    : Scoreboard bench for mem_port_sequencer with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_sequencer;
    import mem_port_sequencer_pkg::*;

    localparam int STARVE = 2;
    localparam int HMASK  = 8191;

    typedef struct {
        int          due;
        logic [1:0]  tag;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mem_port_sequencer_if bus ();

    mem_port_sequencer #(.STARVE_MAX(STARVE)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    logic [15:0] ref_mem [1024];
    logic [15:0] mem     [1024];
    bit          written [1024];
    bit          rd_at   [8192];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last_rdata;
    logic [9:0]  last_addr;
    int          denied;

    logic        rst_v, f_req_v, d_req_v, d_we_v;
    logic [9:0]  f_addr_v, d_addr_v;
    logic [15:0] d_wdata_v;
    bit          fg, dg;

    function automatic logic [15:0] init_val(int i);
        if (i < 3) return 16'hA000 + 16'(i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Write-first synchronous single-port RAM with a known power-up image.
    always @(posedge clk) begin
        if (bus.mem_wea) begin
            mem[bus.mem_addra]     <= bus.mem_dina;
            written[bus.mem_addra] <= 1'b1;
            bus.mem_douta          <= bus.mem_dina;
        end else begin
            bus.mem_douta <= written[bus.mem_addra] ? mem[bus.mem_addra]
                                                    : init_val(int'(bus.mem_addra));
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT returns read data.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) monitor_step();
        end
    end

    task automatic monitor_step();
        int   c;
        exp_t e;
        logic exp_f, exp_d;
        c     = cyc;
        exp_f = 1'b0;
        exp_d = 1'b0;
        if (bus.rvalid_f || bus.rvalid_d) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rvalid: rvalid_f=%b rvalid_d=%b required none at cycle %0d",
                         bus.rvalid_f, bus.rvalid_d, c);
            end else begin
                e = q.pop_front();
                check("rd_latency_cycle", c, e.due);
                exp_f      = (e.tag == TAG_FETCH);
                exp_d      = (e.tag == TAG_DATA);
                last_rdata = e.data;
            end
        end else if (q.size() > 0 && q[0].due <= c) begin
            e = q.pop_front();
            n_total++;
            $display("FAIL missing_rvalid: no rvalid, required tag %0d data %h at cycle %0d",
                     e.tag, e.data, c);
        end
        check("rvalid_f", bus.rvalid_f, exp_f);
        check("rvalid_d", bus.rvalid_d, exp_d);
        check("ir_load", bus.ir_load, exp_f);
        check("rdata", bus.rdata, last_rdata);
        check("busy", bus.busy, rd_at[(c - 1) & HMASK] | rd_at[(c - 2) & HMASK]);
    endtask

    // One clock of stimulus: drive, check arbitration and RAM pins, update model.
    task automatic cycle();
        int   c;
        logic ef, ed;
        exp_t keep[$];
        @(negedge clk);
        reset       = rst_v;
        bus.f_req   = f_req_v;
        bus.f_addr  = f_addr_v;
        bus.d_req   = d_req_v;
        bus.d_we    = d_we_v;
        bus.d_addr  = d_addr_v;
        bus.d_wdata = d_wdata_v;
        #1;
        c = cyc;
        if (rst_v) begin
            ef = 1'b0;
            ed = 1'b0;
        end else begin
            ef = f_req_v && (!d_req_v || denied >= STARVE);
            ed = d_req_v && !ef;
        end
        check("f_gnt", bus.f_gnt, ef);
        check("d_gnt", bus.d_gnt, ed);
        if (ef) begin
            check("mem_addra_fetch", bus.mem_addra, f_addr_v);
            check("mem_wea_fetch", bus.mem_wea, 1'b0);
        end else if (ed) begin
            check("mem_addra_data", bus.mem_addra, d_addr_v);
            check("mem_wea_data", bus.mem_wea, d_we_v);
            if (d_we_v) check("mem_dina", bus.mem_dina, d_wdata_v);
        end else begin
            check("mem_wea_idle", bus.mem_wea, 1'b0);
            check("mem_addra_idle", bus.mem_addra, last_addr);
            if (rst_v) check("mem_dina_reset", bus.mem_dina, 16'h0);
        end

        fg = ef;
        dg = ed;
        rd_at[c & HMASK] = ef || (ed && !d_we_v);
        if (ef) begin
            q.push_back('{c + 2, TAG_FETCH, ref_mem[f_addr_v]});
            last_addr = f_addr_v;
        end else if (ed) begin
            last_addr = d_addr_v;
            if (d_we_v) ref_mem[d_addr_v] = d_wdata_v;
            else q.push_back('{c + 2, TAG_DATA, ref_mem[d_addr_v]});
        end

        if (rst_v) begin
            denied     = 0;
            last_addr  = '0;
            last_rdata = '0;
            rd_at[(c - 1) & HMASK] = 1'b0;
            foreach (q[i]) if (q[i].due <= c) keep.push_back(q[i]);
            q = keep;
        end else if (f_req_v && !ef) begin
            denied++;
        end else begin
            denied = 0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic do_data(logic we, logic [9:0] a, logic [15:0] w);
        d_req_v = 1'b1; d_we_v = we; d_addr_v = a; d_wdata_v = w;
        dg = 1'b0;
        for (int k = 0; k < 40 && !dg; k++) cycle();
        if (!dg) begin
            n_total++;
            $display("FAIL d_grant_timeout: no d_gnt within 40 cycles, required grant");
        end
        d_req_v = 1'b0;
    endtask

    task automatic do_fetch(logic [9:0] a);
        f_req_v = 1'b1; f_addr_v = a;
        fg = 1'b0;
        for (int k = 0; k < 40 && !fg; k++) cycle();
        if (!fg) begin
            n_total++;
            $display("FAIL f_grant_timeout: no f_gnt within 40 cycles, required grant");
        end
        f_req_v = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rst_v = 1'b1;
        f_req_v = 1'b0; d_req_v = 1'b0; d_we_v = 1'b0;
        f_addr_v = '0; d_addr_v = '0; d_wdata_v = '0;
        bus.f_req = 1'b0; bus.f_addr = '0; bus.d_req = 1'b0;
        bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        denied = 0; last_addr = '0; last_rdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        @(posedge clk);
        mon_en = 1'b1;
        idle(3);
        rst_v = 1'b0;

        // Write then fetch of the same word.
        do_data(1'b1, 10'd9, 16'h1D0F);
        do_fetch(10'd9);
        idle(3);

        // Read-after-write on consecutive cycles, then rdata hold.
        do_data(1'b1, 10'd3, 16'h00D0);
        do_data(1'b0, 10'd3, 16'h0000);
        idle(4);

        // Back-to-back fetches of the preloaded words.
        do_fetch(10'd0);
        do_fetch(10'd1);
        do_fetch(10'd2);
        idle(3);

        // Both requesters reading continuously.
        f_req_v = 1'b1; f_addr_v = 10'($urandom_range(1023));
        d_req_v = 1'b1; d_we_v = 1'b0; d_addr_v = 10'($urandom_range(1023));
        repeat (18) begin
            cycle();
            if (fg) f_addr_v = 10'($urandom_range(1023));
            if (dg) d_addr_v = 10'($urandom_range(1023));
        end
        f_req_v = 1'b0; d_req_v = 1'b0;
        idle(3);

        // Data write raised while starved fetch owns the port, then dropped.
        f_req_v = 1'b1; f_addr_v = 10'd7;
        d_req_v = 1'b1; d_we_v = 1'b0; d_addr_v = 10'd8;
        cycle();
        cycle();
        d_we_v = 1'b1; d_addr_v = 10'd20; d_wdata_v = 16'hBEEF;
        cycle();
        d_req_v = 1'b0; f_req_v = 1'b0;
        cycle();
        idle(2);
        do_data(1'b0, 10'd20, 16'h0000);
        idle(3);

        // Reset one cycle after a data read grant.
        do_data(1'b0, 10'd5, 16'h0000);
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        idle(4);

        // Random traffic with occasional drops and resets.
        for (int n = 0; n < 2000; n++) begin
            if (!f_req_v) begin
                if ($urandom_range(2) == 0) begin
                    f_req_v  = 1'b1;
                    f_addr_v = 10'($urandom_range(15));
                end
            end else if ($urandom_range(31) == 0) begin
                f_req_v = 1'b0;
            end
            if (!d_req_v) begin
                if ($urandom_range(2) == 0) begin
                    d_req_v   = 1'b1;
                    d_we_v    = 1'($urandom_range(1));
                    d_addr_v  = 10'($urandom_range(15));
                    d_wdata_v = 16'($urandom);
                end
            end else if ($urandom_range(31) == 0) begin
                d_req_v = 1'b0;
            end
            rst_v = ($urandom_range(149) == 0);
            cycle();
            if (fg) f_req_v = 1'b0;
            if (dg) d_req_v = 1'b0;
        end
        rst_v = 1'b0; f_req_v = 1'b0; d_req_v = 1'b0;
        idle(5);
        check("outstanding_reads", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
